bus_arbiter_2m: RTL and testbench

Two-master round-robin bus arbiter for the shared 32-bit system bus. It grants bus ownership to one of two requesters (M0, M1) and drives the select of the 32-bit 2:1 bus multiplexers for address and write data. A hold counter bounds tenure, so neither master can starve the other. It sits between the two bus masters (e.g. CPU core and DMA) and the single memory/peripheral slave port.

---
 rtl/bus_arbiter_2m_pkg.sv | 12 +
 rtl/bus_arbiter_2m_if.sv | 29 ++
 rtl/bus_arbiter_2m_mux2.sv | 9 +
 rtl/bus_arbiter_2m.sv | 90 +++++++++
 tb/tb_bus_arbiter_2m.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_2m_pkg.sv
// rtl/bus_arbiter_2m_pkg.sv - state encodings and counter width shared by the arbiter
package bus_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// rtl/bus_arbiter_2m_if.sv - two-master request/grant bus plus muxed slave port
interface bus_arbiter_2m_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_wr;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_wr;
    logic        m0_grant;
    logic        m1_grant;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;
    logic        s_sel;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wr,
        input  m1_req, m1_addr, m1_wdata, m1_wr,
        output m0_grant, m1_grant, s_addr, s_wdata, s_wr, s_sel
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wr,
        output m1_req, m1_addr, m1_wdata, m1_wr,
        input  m0_grant, m1_grant, s_addr, s_wdata, s_wr, s_sel
    );
endinterface

// File: rtl/bus_arbiter_2m_mux2.sv
// rtl/bus_arbiter_2m_mux2.sv - 32-bit 2:1 datapath multiplexer
module mux2_32bit (
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master round-robin arbiter with bounded tenure
module bus_arbiter_2m
    import bus_arbiter_2m_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    bus_arbiter_2m_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic             prio, prio_nxt;
    logic             sel_q, sel_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             hold_full;

    assign hold_full = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            sel_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            sel_q    <= sel_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        sel_nxt   = sel_q;
        hold_nxt  = '0;
        case (state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) state_nxt = prio ? GNT1 : GNT0;
                else if (bus.m0_req)          state_nxt = GNT0;
                else if (bus.m1_req)          state_nxt = GNT1;
            end
            GNT0: begin
                if (!bus.m0_req)                 state_nxt = bus.m1_req ? GNT1 : IDLE;
                else if (bus.m1_req && hold_full) state_nxt = GNT1;
            end
            GNT1: begin
                if (!bus.m1_req)                 state_nxt = bus.m0_req ? GNT0 : IDLE;
                else if (bus.m0_req && hold_full) state_nxt = GNT0;
            end
            default: state_nxt = IDLE;
        endcase

        // Tenure counter only runs while a grant is held unchanged; it parks at the limit.
        if (state_nxt == state && state != IDLE)
            hold_nxt = hold_full ? hold_cnt : hold_cnt + 1'b1;

        if (state_nxt != state && state_nxt == GNT0) begin
            prio_nxt = 1'b1;
            sel_nxt  = 1'b0;
        end else if (state_nxt != state && state_nxt == GNT1) begin
            prio_nxt = 1'b0;
            sel_nxt  = 1'b1;
        end
    end

    assign bus.m0_grant = (state == GNT0);
    assign bus.m1_grant = (state == GNT1);
    assign bus.s_sel    = sel_q;
    assign bus.s_wr     = ((state == GNT0) & bus.m0_wr) | ((state == GNT1) & bus.m1_wr);

    mux2_32bit u_addr_mux (
        .sel (sel_q),
        .a   (bus.m0_addr),
        .b   (bus.m1_addr),
        .y   (bus.s_addr)
    );

    mux2_32bit u_wdata_mux (
        .sel (sel_q),
        .a   (bus.m0_wdata),
        .b   (bus.m1_wdata),
        .y   (bus.s_wdata)
    );

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - directed and randomized checks of bus_arbiter_2m
module tb_bus_arbiter_2m;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_2m_if bus ();

    bus_arbiter_2m #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference: who owns the bus, how many cycles it has owned it, who wins a tie,
    // and which master the slave mux last pointed at.
    int owner = 0;
    int held  = 0;
    int prio  = 0;
    int sel   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; held = 0; prio = 0; sel = 0;
    endtask

    task automatic model_edge(input bit r0, input bit r1);
        int nxt;
        nxt = owner;
        if (owner == 0) begin
            if (r0 && r1)  nxt = (prio == 1) ? 2 : 1;
            else if (r0)   nxt = 1;
            else if (r1)   nxt = 2;
        end else if (owner == 1) begin
            if (!r0)                        nxt = r1 ? 2 : 0;
            else if (r1 && held >= MAX_HOLD) nxt = 2;
        end else begin
            if (!r1)                        nxt = r0 ? 1 : 0;
            else if (r0 && held >= MAX_HOLD) nxt = 1;
        end
        if (nxt != owner) begin
            held = (nxt == 0) ? 0 : 1;
            if (nxt == 1) begin prio = 1; sel = 0; end
            if (nxt == 2) begin prio = 0; sel = 1; end
        end else if (nxt != 0) begin
            held++;
        end
        owner = nxt;
    endtask

    task automatic check_all();
        logic exp_wr;
        exp_wr = (owner == 1) ? bus.m0_wr : (owner == 2) ? bus.m1_wr : 1'b0;
        chk("m0_grant", 32'(bus.m0_grant), 32'(owner == 1));
        chk("m1_grant", 32'(bus.m1_grant), 32'(owner == 2));
        chk("s_sel",    32'(bus.s_sel),    32'(sel));
        chk("s_addr",   bus.s_addr,  (sel == 1) ? bus.m1_addr  : bus.m0_addr);
        chk("s_wdata",  bus.s_wdata, (sel == 1) ? bus.m1_wdata : bus.m0_wdata);
        chk("s_wr",     32'(bus.s_wr),     32'(exp_wr));
    endtask

    task automatic step(input bit r0, input bit r1);
        bus.m0_req = r0;
        bus.m1_req = r1;
        @(posedge clk);
        model_edge(r0, r1);
        #1;
        check_all();
    endtask

    task automatic rand_data();
        bus.m0_addr  = $urandom;
        bus.m1_addr  = $urandom;
        bus.m0_wdata = $urandom;
        bus.m1_wdata = $urandom;
        bus.m0_wr    = 1'($urandom_range(0, 1));
        bus.m1_wr    = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        bus.m0_wr = 1'b0;  bus.m1_wr = 1'b0;
        bus.m0_addr = 32'h1000; bus.m1_addr = 32'h2000;
        bus.m0_wdata = 32'h11; bus.m1_wdata = 32'h22;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_s_addr", bus.s_addr, 32'h1000);
        reset_n = 1'b1;
        step(0, 0);
        step(0, 0);

        bus.m1_addr = 32'hCAFE0000;
        bus.m1_wr   = 1'b1;
        step(0, 1);
        chk("single_m1_grant", 32'(bus.m1_grant), 32'd1);
        chk("single_s_addr",   bus.s_addr, 32'hCAFE0000);
        chk("single_s_wr",     32'(bus.s_wr), 32'd1);
        step(0, 0);
        chk("release_m1_grant", 32'(bus.m1_grant), 32'd0);
        chk("release_s_wr",     32'(bus.s_wr), 32'd0);

        // Continuous contention: M0 first, then strict alternation every MAX_HOLD cycles.
        step(1, 1);
        chk("contend_first_m0", 32'(bus.m0_grant), 32'd1);
        for (int i = 1; i < 3 * MAX_HOLD; i++) begin
            step(1, 1);
            chk("contend_alternate", 32'(bus.m1_grant), 32'(((i / MAX_HOLD) % 2) == 1));
        end
        step(0, 0);

        // Back-to-back release at hold_cnt==3.
        step(1, 0);
        repeat (3) step(1, 1);
        step(0, 1);
        chk("b2b_m1_grant", 32'(bus.m1_grant), 32'd1);
        chk("b2b_m0_grant", 32'(bus.m0_grant), 32'd0);
        step(0, 0);

        // Late contention against a saturated counter.
        repeat (20) step(1, 0);
        step(1, 1);
        chk("late_m1_grant", 32'(bus.m1_grant), 32'd1);

        // Asynchronous reset while M1 owns the bus.
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_m1_grant", 32'(bus.m1_grant), 32'd0);
        chk("async_s_sel",    32'(bus.s_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1, 1);
        chk("post_reset_m0", 32'(bus.m0_grant), 32'd1);

        for (int i = 0; i < 400; i++) begin
            rand_data();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
